decrement_then_stop_arst: RTL and testbench

// Loadable down-counter. Counts from a loaded start value toward a loaded end value by a

---
 rtl/decrement_then_stop_arst.sv | 102 ++++++++++
 tb/tb_decrement_then_stop_arst.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/decrement_then_stop_arst.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | decrement_then_stop_arst: loadable saturating down-counter with done pulse |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module decrement_then_stop_arst #(
  parameter int Bits = 8
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            load_valid_i,
  output logic            load_ready_o,
  input  logic [Bits-1:0] start_val_i,
  input  logic [Bits-1:0] end_val_i,
  input  logic [Bits-1:0] step_i,
  input  logic            en_i,
  input  logic            abort_i,
  output logic [Bits-1:0] count_o,
  output logic            busy_o,
  output logic            done_o,
  input  logic            assert_on_i
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [Bits-1:0] c_one = Bits'(1);

  state_t          r_state;
  logic [Bits-1:0] r_count;
  logic [Bits-1:0] r_end;
  logic [Bits-1:0] r_step;
  logic            r_done;

  logic            w_load;
  logic [Bits-1:0] w_step_ld;
  logic [Bits-1:0] w_rem;
  logic            w_last;

  assign load_ready_o = (r_state != ST_RUN);
  assign busy_o       = (r_state == ST_RUN);
  assign count_o      = r_count;
  assign done_o       = r_done;

  assign w_load    = load_valid_i & load_ready_o & ~abort_i;
  assign w_step_ld = (step_i == '0) ? c_one : step_i;
  // count >= end holds throughout RUN, so this subtraction cannot underflow
  assign w_rem     = r_count - r_end;
  assign w_last    = (w_rem <= r_step);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= ST_IDLE;
      r_count <= '0;
      r_end   <= '0;
      r_step  <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (abort_i) begin
        r_state <= ST_IDLE;
      end else if (w_load) begin
        r_count <= start_val_i;
        r_end   <= end_val_i;
        r_step  <= w_step_ld;
        if (start_val_i == end_val_i) begin
          r_state <= ST_DONE;
          // an immediate re-entry from DONE must not stretch the pulse
          r_done  <= ~r_done;
        end else begin
          r_state <= ST_RUN;
        end
      end else if (r_state == ST_RUN && en_i) begin
        if (w_last) begin
          r_count <= r_end;
          r_state <= ST_DONE;
          r_done  <= 1'b1;
        end else begin
          r_count <= r_count - r_step;
        end
      end
    end
  end

  always @(posedge clk_i) begin
    if (rst_ni && assert_on_i) begin
      if (w_load) begin
        assert (end_val_i <= start_val_i)
          else $error("load end_val_i=%h exceeds start_val_i=%h", end_val_i, start_val_i);
      end
      if (r_state != ST_IDLE) begin
        assert (r_count >= r_end)
          else $error("count_o=%h below end=%h", r_count, r_end);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_decrement_then_stop_arst.sv
`default_nettype none
// Self-checking bench for decrement_then_stop_arst: directed scenarios plus
// random traffic against an arithmetic reference model.
module tb_decrement_then_stop_arst;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       load_valid_i;
  logic       load_ready_o;
  logic [7:0] start_val_i;
  logic [7:0] end_val_i;
  logic [7:0] step_i;
  logic       en_i;
  logic       abort_i;
  logic [7:0] count_o;
  logic       busy_o;
  logic       done_o;
  logic       assert_on_i;

  int checks   = 0;
  int failures = 0;

  // reference model: counting flag plus plain integer arithmetic
  int m_count, m_end, m_step;
  bit m_run, m_done;
  bit saw_done;
  int done_count_val;

  always #5 clk_i = ~clk_i;

  decrement_then_stop_arst #(.Bits(8)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .load_valid_i (load_valid_i),
    .load_ready_o (load_ready_o),
    .start_val_i  (start_val_i),
    .end_val_i    (end_val_i),
    .step_i       (step_i),
    .en_i         (en_i),
    .abort_i      (abort_i),
    .count_o      (count_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .assert_on_i  (assert_on_i)
  );

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp)
      else begin
        failures++;
        $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".count"}, int'(count_o), m_count);
    check({tag, ".busy"},  int'(busy_o),  int'(m_run));
    check({tag, ".ready"}, int'(load_ready_o), int'(!m_run));
    check({tag, ".done"},  int'(done_o),  int'(m_done));
  endtask

  task automatic drive(input bit v, input int s, input int e, input int st,
                       input bit en, input bit ab);
    load_valid_i = v;
    start_val_i  = 8'(s);
    end_val_i    = 8'(e);
    step_i       = 8'(st);
    en_i         = en;
    abort_i      = ab;
  endtask

  task automatic model_reset();
    m_count = 0; m_end = 0; m_step = 0; m_run = 0; m_done = 0;
  endtask

  // advance the model with the inputs currently applied, clock, then compare
  task automatic tick(input string tag);
    bit n_done;
    n_done = 0;
    if (abort_i) begin
      m_run = 0;
    end else if (load_valid_i && !m_run) begin
      m_count = start_val_i;
      m_end   = end_val_i;
      m_step  = (step_i == 0) ? 1 : int'(step_i);
      if (start_val_i == end_val_i) begin
        m_run  = 0;
        n_done = !m_done;
      end else begin
        m_run = 1;
      end
    end else if (m_run && en_i) begin
      if (m_count - m_end <= m_step) begin
        m_count = m_end;
        m_run   = 0;
        n_done  = 1;
      end else begin
        m_count = m_count - m_step;
      end
    end
    m_done = n_done;
    @(posedge clk_i);
    #1;
    check_all(tag);
    if (done_o) begin
      saw_done = 1;
      done_count_val = count_o;
    end
  endtask

  task automatic run_until_idle(input string tag, input int budget);
    int n;
    n = 0;
    while (m_run && n < budget) begin
      tick(tag);
      n++;
    end
    check({tag, ".budget"}, int'(n < budget), 1);
  endtask

  initial begin
    assert_on_i = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    model_reset();
    rst_ni = 1'b0;
    #3;
    check("reset.count", int'(count_o), 0);
    check("reset.busy",  int'(busy_o),  0);
    check("reset.done",  int'(done_o),  0);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    @(posedge clk_i); #1;
    check_all("post_reset");

    // 10 -> 3 step 1
    drive(1, 10, 3, 1, 1, 0); tick("s1.load");
    check("s1.first", int'(count_o), 10);
    load_valid_i = 0; saw_done = 0;
    run_until_idle("s1", 20);
    check("s1.saw_done", int'(saw_done), 1);
    check("s1.done_at",  done_count_val, 3);
    tick("s1.hold"); tick("s1.hold");
    check("s1.final", int'(count_o), 3);

    // 20 -> 5 step 4, saturating last step
    drive(1, 20, 5, 4, 1, 0); tick("s2.load");
    load_valid_i = 0; saw_done = 0;
    tick("s2.c16"); check("s2.16", int'(count_o), 16);
    tick("s2.c12"); tick("s2.c8"); check("s2.8", int'(count_o), 8);
    tick("s2.c5");  check("s2.5", int'(count_o), 5);
    check("s2.done", int'(done_o), 1);
    tick("s2.hold");

    // start == end
    drive(1, 7, 7, 2, 1, 0); tick("s3.load");
    check("s3.done", int'(done_o), 1);
    check("s3.busy", int'(busy_o), 0);
    load_valid_i = 0;
    tick("s3.after");
    check("s3.pulse", int'(done_o), 0);

    // 0xFF -> 0 step 0 (as 1), en toggling
    drive(1, 255, 0, 0, 0, 0); tick("s4.load");
    load_valid_i = 0;
    for (int i = 0; i < 600 && m_run; i++) begin
      en_i = i[0];
      tick("s4.run");
    end
    check("s4.final", int'(count_o), 0);
    en_i = 1; tick("s4.hold");
    check("s4.nowrap", int'(count_o), 0);

    // abort at count 12 with en and load both asserted
    drive(1, 20, 0, 4, 1, 0); tick("s5.load");
    load_valid_i = 0;
    tick("s5.c16"); tick("s5.c12");
    check("s5.at12", int'(count_o), 12);
    drive(1, 100, 50, 1, 1, 1); tick("s5.abort");
    check("s5.held", int'(count_o), 12);
    check("s5.idle", int'(busy_o), 0);
    drive(1, 4, 2, 1, 1, 0); tick("s5.reload");
    load_valid_i = 0;
    run_until_idle("s5.run", 10);
    check("s5.final", int'(count_o), 2);

    // async reset mid-RUN
    drive(1, 50, 10, 3, 1, 0); tick("s6.load");
    load_valid_i = 0;
    tick("s6.run"); tick("s6.run");
    #1; rst_ni = 1'b0; model_reset();
    #1;
    check("s6.rst_count", int'(count_o), 0);
    check("s6.rst_busy",  int'(busy_o),  0);
    check("s6.rst_done",  int'(done_o),  0);
    rst_ni = 1'b1;
    drive(1, 6, 5, 1, 1, 0); tick("s6.load");
    load_valid_i = 0;
    tick("s6.step");
    check("s6.done", int'(done_o), 1);
    check("s6.end",  int'(count_o), 5);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      int s, e;
      s = $urandom_range(0, 255);
      e = $urandom_range(0, s);
      if ($urandom_range(0, 3) == 0) e = s;
      drive($urandom_range(0, 2) == 0, s, e, $urandom_range(0, 9),
            $urandom_range(0, 3) != 0, $urandom_range(0, 24) == 0);
      tick("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
